// File: rtl/mdu_pkg.sv
// Shared constants and enumerations for the multiply/divide unit.
// Optional feature macro: MDU_FAST_MUL_EN (single-cycle multiplier).
package mdu_pkg;

  localparam int WORD_WIDTH   = 32;
  localparam int WORD_INDEX_W = 5;
  localparam int MDUOP_WIDTH  = 3;

  // Operation codes presented on mdu_op; 3'd7 is deliberately unused.
  typedef enum logic [MDUOP_WIDTH-1:0] {
    MDU_NOP   = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_e;

  // Sequencer states: idle, 32 datapath iterations, then sign fix-up/write-back.
  typedef enum logic [1:0] {
    MDU_ST_IDLE = 2'd0,
    MDU_ST_CALC = 2'd1,
    MDU_ST_SIGN = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter_core.sv
// Unsigned iterative datapath: radix-2 shift-add multiply and restoring
// shift-subtract divide over a 2W accumulator. One step per enabled cycle.
// For divide the accumulator ends as {remainder, quotient}; for multiply
// it ends as the full product.
module mdu_iter_core
  import mdu_pkg::*;
#(
  parameter int W     = WORD_WIDTH,
  parameter int CNT_W = WORD_INDEX_W + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_i,
  input  logic           step_i,
  input  logic           isDiv_i,
  input  logic [W-1:0]   opA_i,
  input  logic [W-1:0]   opB_i,
  output logic [2*W-1:0] acc_o,
  output logic           lastStep_o
);

  logic [2*W-1:0]   acc_q, acc_d;
  logic [W-1:0]     opB_q;
  logic             isDiv_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W:0]       mulSum;
  logic [W:0]       remShift;
  logic [W:0]       remDiff;

  // Next accumulator: load the first operand, or perform one add/shift or shift/subtract step.
  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mulSum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opB_q} : '0);
    remShift = acc_q[2*W-1:W-1];
    remDiff  = remShift - {1'b0, opB_q};
    if (load_i) begin
      acc_d = {{W{1'b0}}, opA_i};
      cnt_d = '0;
    end else if (step_i) begin
      cnt_d = cnt_q + 1'b1;
      if (isDiv_q) begin
        if (!remDiff[W]) begin
          acc_d = {remDiff[W-1:0], acc_q[W-2:0], 1'b1};
        end else begin
          acc_d = {remShift[W-1:0], acc_q[W-2:0], 1'b0};
        end
      end else begin
        acc_d = {mulSum, acc_q[W-1:1]};
      end
    end
  end

  // Accumulator, counter and latched second operand/op kind.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      opB_q   <= '0;
      isDiv_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      if (load_i) begin
        opB_q   <= opB_i;
        isDiv_q <= isDiv_i;
      end
    end
  end

  assign acc_o      = acc_q;
  assign lastStep_o = (cnt_q == CNT_W'(W - 1));

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit owning the HI/LO registers: sequencer, operand sign
// handling, result fix-up, MTHI/MTLO and flush. The iterative datapath lives
// in mdu_iter_core. Define MDU_FAST_MUL_EN to make MULT/MULTU single-cycle.
module mdu
  import mdu_pkg::*;
#(
  parameter int W     = WORD_WIDTH,
  parameter int CNT_W = WORD_INDEX_W + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [MDUOP_WIDTH-1:0] mdu_op,
  input  logic [W-1:0]           rs_val,
  input  logic [W-1:0]           rt_val,
  input  logic                   flush,
  output logic                   busy,
  output logic                   done,
  output logic [W-1:0]           hi,
  output logic [W-1:0]           lo
);

  mdu_state_e     state_q, state_d;
  logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic           done_q, done_d;
  logic           isDiv_q, negA_q, negB_q, divZero_q;
  logic           coreLoad, coreStep, coreLast;
  logic [2*W-1:0] coreAcc;
  logic           isSignedOp, isDivOp;
  logic [W-1:0]   rsMag, rtMag, quot, rem;
`ifdef MDU_FAST_MUL_EN
  logic [2*W-1:0] fastProd;
`endif

  assign isSignedOp = (mdu_op == MDU_MULT) || (mdu_op == MDU_DIV);
  assign isDivOp    = (mdu_op == MDU_DIV) || (mdu_op == MDU_DIVU);
  assign rsMag      = (isSignedOp && rs_val[W-1]) ? -rs_val : rs_val;
  assign rtMag      = (isSignedOp && rt_val[W-1]) ? -rt_val : rt_val;
  assign quot       = coreAcc[W-1:0];
  assign rem        = coreAcc[2*W-1:W];

`ifdef MDU_FAST_MUL_EN
  // Single-cycle product; signed operands sign-extend to the full 2W width.
  always_comb begin
    if (mdu_op == MDU_MULT) begin
      fastProd = $signed(rs_val) * $signed(rt_val);
    end else begin
      fastProd = {{W{1'b0}}, rs_val} * {{W{1'b0}}, rt_val};
    end
  end
`endif

  mdu_iter_core #(.W(W), .CNT_W(CNT_W)) u_core (
    .clk        (clk),
    .rst        (rst),
    .load_i     (coreLoad),
    .step_i     (coreStep),
    .isDiv_i    (isDivOp),
    .opA_i      (rsMag),
    .opB_i      (rtMag),
    .acc_o      (coreAcc),
    .lastStep_o (coreLast)
  );

  // Sequencer next state, HI/LO next values and done pulse; flush squashes everything.
  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    coreLoad = 1'b0;
    coreStep = 1'b0;
    case (state_q)
      MDU_ST_IDLE: begin
        if (start) begin
          case (mdu_op)
            MDU_MULT, MDU_MULTU: begin
`ifdef MDU_FAST_MUL_EN
              {hi_d, lo_d} = fastProd;
              done_d       = 1'b1;
`else
              coreLoad = 1'b1;
              state_d  = MDU_ST_CALC;
`endif
            end
            MDU_DIV, MDU_DIVU: begin
              coreLoad = 1'b1;
              state_d  = MDU_ST_CALC;
            end
            MDU_MTHI: hi_d = rs_val;
            MDU_MTLO: lo_d = rs_val;
            default: ;
          endcase
        end
      end
      MDU_ST_CALC: begin
        coreStep = 1'b1;
        if (coreLast) begin
          state_d = MDU_ST_SIGN;
        end
      end
      MDU_ST_SIGN: begin
        state_d = MDU_ST_IDLE;
        done_d  = 1'b1;
        if (isDiv_q) begin
          lo_d = ((negA_q ^ negB_q) && !divZero_q) ? -quot : quot;
          hi_d = negA_q ? -rem : rem;
        end else begin
          {hi_d, lo_d} = (negA_q ^ negB_q) ? -coreAcc : coreAcc;
        end
      end
      default: state_d = MDU_ST_IDLE;
    endcase
    if (flush) begin
      state_d  = MDU_ST_IDLE;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      coreLoad = 1'b0;
      coreStep = 1'b0;
    end
  end

  // Architectural state plus operand signs captured when an iterative op is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MDU_ST_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      isDiv_q   <= 1'b0;
      negA_q    <= 1'b0;
      negB_q    <= 1'b0;
      divZero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      if (coreLoad) begin
        isDiv_q   <= isDivOp;
        negA_q    <= isSignedOp && rs_val[W-1];
        negB_q    <= isSignedOp && rt_val[W-1];
        divZero_q <= (rt_val == '0);
      end
    end
  end

  assign busy = (state_q != MDU_ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard testbench for mdu: stimulus pushes expected {hi,lo} from a plain
// arithmetic reference model; a monitor pops and compares on every done pulse.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] rs_val, rt_val;
  logic        flush;
  logic        busy, done;
  logic [31:0] hi, lo;

  logic [63:0] sbQueue[$];
  logic [31:0] modelHi, modelLo;
  int          checkCount = 0;
  int          passCount  = 0;

  mdu dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mdu_op (mdu_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Watchdog so a stuck design still terminates.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: results straight from the arithmetic definitions.
  function automatic logic [63:0] refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    case (op)
      MDU_MULT:  r = sa * sb;
      MDU_MULTU: r = {32'd0, a} * {32'd0, b};
      MDU_DIV:   if (b == 0) r = {a, 32'hFFFFFFFF};
                 else begin
                   longint q, m;
                   q = sa / sb;
                   m = sa % sb;
                   r = {m[31:0], q[31:0]};
                 end
      MDU_DIVU:  if (b == 0) r = {a, 32'hFFFFFFFF};
                 else r = {a % b, a / b};
      default:   r = {modelHi, modelLo};
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sbQueue.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpectedDone: got done=1 with hi=%h lo=%h, expected no pulse", hi, lo);
      end else begin
        checkOutput("hiLoResult", {hi, lo}, sbQueue.pop_front());
      end
    end
  end

  // Issue one MULT/MULTU/DIV/DIVU, optionally hammering start while busy.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit interfere);
    logic [63:0] exp;
    int busyCnt, expBusy;
    bit seen;
    exp = refModel(op, a, b);
    sbQueue.push_back(exp);
    @(negedge clk);
    start = 1'b1; mdu_op = op; rs_val = a; rt_val = b;
    @(posedge clk);
    busyCnt = 0; seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1; start = 1'b0;
        break;
      end
      if (busy) busyCnt++;
      if (interfere && busy) begin
        start = 1'b1; mdu_op = 3'($urandom_range(1, 4));
        rs_val = $urandom; rt_val = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    modelHi = exp[63:32];
    modelLo = exp[31:0];
`ifdef MDU_FAST_MUL_EN
    expBusy = (op == MDU_MULT || op == MDU_MULTU) ? 0 : 33;
`else
    expBusy = 33;
`endif
    checkOutput("doneSeen", 64'(seen), 64'd1);
    checkOutput("busyCycles", 64'(busyCnt), 64'(expBusy));
    @(negedge clk);
    checkOutput("donePulseWidth", 64'(done), 64'd0);
  endtask

  // Main sequence: reset, directed cases, flush, reset mid-op, random ops.
  initial begin
    rst = 1'b1; start = 1'b0; mdu_op = MDU_NOP; rs_val = '0; rt_val = '0; flush = 1'b0;
    modelHi = '0; modelLo = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("resetHiLo", {hi, lo}, 64'd0);
    checkOutput("resetBusyDone", {62'd0, busy, done}, 64'd0);
    rst = 1'b0;

    applyStimulus(MDU_MULT,  32'hFFFFFFFE, 32'h00000003, 1'b0);
    applyStimulus(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    applyStimulus(MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 1'b0);
    applyStimulus(MDU_DIVU,  32'h00000007, 32'h00000000, 1'b0);
    applyStimulus(MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 1'b0);
    applyStimulus(MDU_DIV,   32'hFFFFFFF9, 32'h00000000, 1'b0);
    applyStimulus(MDU_DIV,   32'h00000064, 32'hFFFFFFF9, 1'b1);

    // MTHI then MTLO on back-to-back edges
    @(negedge clk);
    start = 1'b1; mdu_op = MDU_MTHI; rs_val = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    checkOutput("mthiHi", 64'(hi), 64'h12345678);
    checkOutput("mthiBusyDone", {62'd0, busy, done}, 64'd0);
    mdu_op = MDU_MTLO; rs_val = 32'h9ABCDEF0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checkOutput("mtloHiLo", {hi, lo}, 64'h12345678_9ABCDEF0);
    checkOutput("mtloBusyDone", {62'd0, busy, done}, 64'd0);
    modelHi = 32'h12345678; modelLo = 32'h9ABCDEF0;

    // Unknown opcode must do nothing
    start = 1'b1; mdu_op = 3'd7; rs_val = 32'hDEADBEEF; rt_val = 32'h1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checkOutput("unknownOpHiLo", {hi, lo}, {modelHi, modelLo});
    checkOutput("unknownOpBusy", {62'd0, busy, done}, 64'd0);

    // Flush an in-flight DIVU, then rerun it to completion
    start = 1'b1; mdu_op = MDU_DIVU; rs_val = 32'd100; rt_val = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flushBusyDone", {62'd0, busy, done}, 64'd0);
    checkOutput("flushHiLo", {hi, lo}, {modelHi, modelLo});
    applyStimulus(MDU_DIVU, 32'd100, 32'd7, 1'b0);

    // Flush racing a start: flush wins
    @(negedge clk);
    start = 1'b1; flush = 1'b1; mdu_op = MDU_MTHI; rs_val = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    checkOutput("flushBeatsStart", {hi, 30'd0, busy, done}, {modelHi, 32'd0});

    // Reset in the middle of an iterative op
    start = 1'b1; mdu_op = MDU_DIV; rs_val = 32'h0BADF00D; rt_val = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midOpResetHiLo", {hi, lo}, 64'd0);
    checkOutput("midOpResetBusyDone", {62'd0, busy, done}, 64'd0);
    modelHi = '0; modelLo = '0;

    // Randomised operations, some with start hammered while busy
    for (int i = 0; i < 16; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(1, 4));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 5) == 0) b = '0;
      else if ($urandom_range(0, 2) == 0) b = 32'($urandom_range(1, 20));
      applyStimulus(op, a, b, (i % 3) == 0);
    end

    repeat (3) @(negedge clk);
    checkOutput("scoreboardEmpty", 64'(sbQueue.size()), 64'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
